// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types and default sizes.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                       err;
    logic [UART_DATA_WIDTH-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - consumer-side head-entry handshake of the receive FIFO.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_err;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_err, output m_valid, input m_ready);
  modport slave  (input m_data, input m_err, input m_valid, output m_ready);

endinterface

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - register array, one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through FIFO behind a UART receiver.
// UART_RX_FIFO_DROP_ERR_EN: drop errored characters and count them on err_drops.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = UART_DATA_WIDTH,
  parameter  int DEPTH      = UART_FIFO_DEPTH,
  parameter  int AFULL_LVL  = 12,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_error,
  input  logic                  flush,
  uart_rx_fifo_if.master        m_if,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  ovf_clr
`ifdef UART_RX_FIFO_DROP_ERR_EN
  ,
  output logic [7:0]            err_drops
`endif
);

  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  m_valid;
  logic                  cand, push, pop, ovf_set;
  logic [DATA_WIDTH:0]   rdata;

  // Pointers carry one wrap bit so full and empty stay distinguishable.
  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AFULL_LVL));
  assign overflow    = ovf_q;
  assign m_valid     = ~empty;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic [7:0] drops_q, drops_d;

  assign cand      = rx_valid & ~rx_error;
  assign err_drops = drops_q;

  always_comb begin
    drops_d = drops_q;
    if (rx_valid && rx_error && drops_q != 8'hFF) begin
      drops_d = drops_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drops_q <= '0;
    end else begin
      drops_q <= drops_d;
    end
  end
`else
  assign cand = rx_valid;
`endif

  always_comb begin
    pop      = m_valid & m_if.m_ready;
    push     = cand & ~flush & (~full | pop);
    ovf_set  = cand & ~flush & full & ~pop;
    wr_ptr_d = wr_ptr_q + CW'(push);
    rd_ptr_d = rd_ptr_q + CW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_fifo_mem #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({rx_error, rx_data}),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  // Head outputs are forced to zero when nothing is stored.
  assign m_if.m_valid = m_valid;
  assign m_if.m_data  = m_valid ? rdata[DATA_WIDTH-1:0] : '0;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign m_if.m_err   = 1'b0;
`else
  assign m_if.m_err   = m_valid & rdata[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo, directed scenarios then random traffic.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk = 1'b0;
  logic       rst, rx_valid, rx_error, flush, ovf_clr, rdy;
  logic [7:0] rx_data;
  logic [4:0] count;
  logic       empty, full, almost_full, overflow;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic [7:0] err_drops;
`endif

  uart_rx_fifo_if #(.DATA_WIDTH(8)) mif ();
  assign mif.m_ready = rdy;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_error    (rx_error),
    .flush       (flush),
    .m_if        (mif.master),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
`ifdef UART_RX_FIFO_DROP_ERR_EN
    ,
    .err_drops   (err_drops)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;
  bit pop_pend = 1'b0;
  bit m_ovf = 1'b0;
  int m_drops = 0;
  uart_rx_entry_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a queue of entries updated at each edge from the sampled inputs.
  always @(posedge clk) begin
    int sz;
    bit cand;
    bit ovf_set;
    if (rst) begin
      exp_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      sz      = exp_q.size() + (pop_pend ? 1 : 0);
      cand    = rx_valid;
      ovf_set = 1'b0;
`ifdef UART_RX_FIFO_DROP_ERR_EN
      if (rx_valid && rx_error) begin
        cand = 1'b0;
        if (m_drops < 255) m_drops++;
      end
`endif
      if (flush) begin
        exp_q.delete();
      end else if (cand) begin
        if (sz < DEPTH || pop_pend) exp_q.push_back({rx_error, rx_data});
        else ovf_set = 1'b1;
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
    pop_pend = 1'b0;
  end

  // Monitor: compares status every cycle, pops the scoreboard when the consumer takes the head.
  always @(negedge clk) begin
    uart_rx_entry_t e;
    if (started) begin
      chk("count", int'(count), exp_q.size());
      chk("empty", int'(empty), int'(exp_q.size() == 0));
      chk("full", int'(full), int'(exp_q.size() == DEPTH));
      chk("almost_full", int'(almost_full), int'(exp_q.size() >= AFULL));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("m_valid", int'(mif.m_valid), int'(exp_q.size() != 0));
`ifdef UART_RX_FIFO_DROP_ERR_EN
      chk("err_drops", int'(err_drops), m_drops);
`endif
      if (mif.m_valid && exp_q.size() != 0) begin
        e = exp_q[0];
        chk("head_data", int'(mif.m_data), int'(e.data));
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk("head_err", int'(mif.m_err), 0);
`else
        chk("head_err", int'(mif.m_err), int'(e.err));
`endif
        if (!rst && !flush && rdy) begin
          void'(exp_q.pop_front());
          pop_pend = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d, input bit e, input bit r,
                     input bit f, input bit c, input bit rs);
    rx_valid = v; rx_data = d; rx_error = e; rdy = r;
    flush = f; ovf_clr = c; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
    flush = 1'b0; ovf_clr = 1'b0; rdy = 1'b0;
    @(posedge clk);
    #1;
    started = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_m_data", int'(mif.m_data), 0);
    chk("rst_m_err", int'(mif.m_err), 0);
    chk("rst_overflow", int'(overflow), 0);

    push(8'hA5);
    chk("fwft_valid", int'(mif.m_valid), 1);
    chk("fwft_data", int'(mif.m_data), 8'hA5);
    chk("fwft_err", int'(mif.m_err), 0);
    chk("fwft_count", int'(count), 1);
    drain(1);

    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk("fill_afull", int'(almost_full), int'(i + 1 >= 12));
      chk("fill_full", int'(full), int'(i + 1 == 16));
    end
    push(8'hFF);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_set_wins", int'(overflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", int'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", int'(mif.m_data), i);
      drain(1);
    end

    for (int i = 0; i < 16; i++) push(8'(i));
    cyc(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_pushpop_count", int'(count), 16);
    drain(15);
    chk("full_pushpop_last", int'(mif.m_data), 8'h3C);
    drain(1);

    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_DROP_ERR_EN
    chk("err_drop_count", int'(count), 0);
    chk("err_drops", int'(err_drops), 1);
`else
    chk("err_m_err", int'(mif.m_err), 1);
    chk("err_m_data", int'(mif.m_data), 8'h55);
`endif
    drain(1);

    for (int i = 0; i < 5; i++) push(8'(8'h80 + i));
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_count", int'(count), 0);
    chk("rst_mid_empty", int'(empty), 1);
    chk("rst_mid_valid", int'(mif.m_valid), 0);

    for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
    drain(11);
    chk("pre_flush_count", int'(count), 5);
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_count", int'(count), 0);
    chk("flush_ovf_kept", int'(overflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 79) == 0),
          1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 299) == 0));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- DATA_WIDTH, 8, character width; equal to the upstream receiver's width.
- DEPTH, 16, number of entries; must be a power of 2 and at least 4.
- AFULL_LVL, 12, count at or above which almost_full asserts; range 1..DEPTH.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock; rising edge.
- rst, in, 1, synchronous, active-high reset.
- rx_data, in, DATA_WIDTH, received character from the UART receiver.
- rx_valid, in, 1, one-cycle strobe; a character is present. There is no backpressure.
- rx_error, in, 1, parity or framing error for the strobed character.
- flush, in, 1, synchronous empty command.
- m_data, out, DATA_WIDTH, head character.
- m_err, out, 1, error flag of the head character.
- m_valid, out, 1, head entry valid.
- m_ready, in, 1, consumer accepts the head entry.
- count, out, $clog2(DEPTH)+1, number of stored entries.
- empty, out, 1, count==0.
- full, out, 1, count==DEPTH.
- almost_full, out, 1, count>=AFULL_LVL.
- overflow, out, 1, sticky flag: a character was lost.
- ovf_clr, in, 1, clears overflow.

Function
REQ-003 A push SHALL occur on any cycle with rx_valid=1 that is accepted under REQ-007; the entry written is {rx_error, rx_data}.
REQ-004 A pop SHALL occur on any cycle with m_valid=1 and m_ready=1.
REQ-005 The output SHALL be first-word-fall-through: a push into an empty FIFO at edge N SHALL give m_valid=1 with that data after edge N, with no extra cycle.
REQ-006 m_data and m_err SHALL hold stable while m_valid=1 and m_ready=0.
REQ-007 Push while full SHALL be handled as follows:
- With a simultaneous pop: the push is accepted and count is unchanged.
- Without a pop: the character is discarded and overflow is set after that edge.
REQ-008 A pop and a push on the same cycle when count==0 SHALL be impossible, because m_valid=0; only the push takes effect.
REQ-009 Read and write pointers SHALL wrap modulo DEPTH. count SHALL equal wr_ptr-rd_ptr computed with one extra wrap bit.
REQ-010 overflow SHALL be cleared on the edge where ovf_clr=1. If the set condition and ovf_clr occur on the same cycle, the set SHALL win.
REQ-011 flush=1 SHALL zero both pointers at the next edge. overflow SHALL be kept. A push on the flush cycle SHALL be discarded without setting overflow.
REQ-012 empty, full and almost_full SHALL be decoded combinationally from the registered count.

Reset
REQ-013 With rst=1 at an edge, the block SHALL clear the pointers and count, set m_valid=0, empty=1, full=0, almost_full=0 and overflow=0, and drive m_data and m_err to 0.
REQ-014 A reset asserted mid-operation SHALL discard all stored entries. A push or pop on the reset cycle SHALL be ignored.
REQ-015 Storage array contents SHALL NOT require reset.

Configuration
REQ-016 With the macro UART_RX_FIFO_DROP_ERR_EN defined:
- Characters strobed with rx_error=1 SHALL NOT be written.
- They SHALL increment an 8-bit output err_drops, which saturates at 255 and resets to 0.
- m_err SHALL be tied to 0.
REQ-017 With UART_RX_FIFO_DROP_ERR_EN undefined, errored characters SHALL be stored with m_err=1, and the err_drops port SHALL be absent.

Structure
REQ-018 The following SHALL be defined in the shared package uart_pkg, which this block imports:
- the entry typedef uart_rx_entry_t {err, data};
- the default DATA_WIDTH;
- the default DEPTH.
REQ-019 Storage SHALL be a sub-module uart_fifo_mem: a register array with one synchronous write port and one asynchronous read port. Pointer, count and flag logic SHALL stay in uart_rx_fifo.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Single push of 0xA5, rx_error=0, into an empty FIFO -> m_valid=1, m_data=0xA5, m_err=0 on the next cycle; count=1.
- 16 pushes of 0x00..0x0F with m_ready=0 -> full=1 and almost_full=1 from the 12th entry. A 17th push of 0xFF -> overflow=1, count=16. Draining then yields 0x00..0x0F in order.
- Full FIFO, push 0x3C and pop on the same cycle -> count stays 16; 0x3C emerges 16th after the pop.
- Push 0x55 with rx_error=1 -> macro undefined: m_err=1; macro defined: no entry and err_drops=1.
- overflow=1, with ovf_clr=1 on the same cycle as a fresh overflow -> overflow remains 1. ovf_clr alone -> 0.
- 5 entries stored, then rst=1 for one cycle together with a push -> count=0, empty=1, m_valid=0. flush of 5 entries -> count=0 with overflow unchanged.
